// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and helpers for the MEM stage load/store unit.
// Holds the pipeline field types, the memory funct3 encoding, the LSU
// state enum, the latched request and MEM/WB record layouts, and
// the helper functions that do store-side alignment and misalignment checks.
package mem_stage_lsu_pkg;

  typedef logic [31:0] data_t;
  typedef logic        enable_t;
  typedef logic [4:0]  reg_addr_t;

  // Selects which value the WB stage writes back to the register file.
  typedef enum logic [1:0] {
    WB_ALU     = 2'b00,
    WB_MEM     = 2'b01,
    WB_PC_NEXT = 2'b10
  } wb_data_sel_t;

  // Store encodings reuse the load ones: SB=LB, SH=LH, SW=LW.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_funct3_t;

  typedef enum logic {
    LSU_IDLE,
    LSU_WAIT
  } lsu_state_t;

  // Everything about an in-flight access. This record is captured when the
  // access is accepted, so it survives while the EX/MEM register is stalled.
  typedef struct packed {
    data_t        addr;
    logic         we;
    logic [3:0]   wstrb;
    data_t        wdata;
    mem_funct3_t  funct3;
    reg_addr_t    rd;
    enable_t      reg_write;
    wb_data_sel_t wb_sel;
    data_t        pc_next;
  } lsu_req_t;

  // MEM/WB pipeline register contents.
  typedef struct packed {
    logic         valid;
    data_t        alu_result;
    data_t        mem_rdata;
    reg_addr_t    rd;
    enable_t      reg_write;
    wb_data_sel_t wb_sel;
    data_t        pc_next;
    logic         misalign;
    logic         bus_err;
  } memwb_t;

  // Undefined encodings are reported as misaligned. Stores have no
  // unsigned forms, so LBU/LHU are undefined when is_store is set.
  function automatic logic access_misaligned(mem_funct3_t f, logic is_store,
                                             logic [1:0] a);
    logic bad;
    case (f)
      LB:      bad = 1'b0;
      LH:      bad = a[0];
      LW:      bad = (a != 2'b00);
      LBU:     bad = is_store;
      LHU:     bad = is_store | a[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_strobe(mem_funct3_t f, logic [1:0] a);
    logic [3:0] s;
    case (f)
      LB:      s = 4'b0001 << a;
      LH:      s = 4'b0011 << a;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // The data is copied across all byte lanes, so the strobes alone select
  // which lanes the memory actually writes.
  function automatic data_t store_data(mem_funct3_t f, data_t d);
    data_t w;
    case (f)
      LB:      w = {4{d[7:0]}};
      LH:      w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data aligner: picks the byte or halfword addressed by addr_lo_i out
// of the raw memory word and sign- or zero-extends it according to funct3.
// Ports:
//   rdata_i    raw 32-bit word returned by data memory
//   addr_lo_i  low two address bits of the access
//   funct3_i   load size/sign encoding
//   data_o     aligned, extended load value (0 for undefined encodings)
module lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  data_t       rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  mem_funct3_t funct3_i,
  output data_t       data_o
);

  data_t shifted;

  // The addressed byte/half is moved down to bit 0, then extended.
  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    case (funct3_i)
      LB:      data_o = {{24{shifted[7]}}, shifted[7:0]};
      LBU:     data_o = {24'h000000, shifted[7:0]};
      LH:      data_o = {{16{shifted[15]}}, shifted[15:0]};
      LHU:     data_o = {16'h0000, shifted[15:0]};
      LW:      data_o = rdata_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage of the 5-stage RV32I pipeline.
// Drives a req/ack data-memory port, holding the request for as many cycles
// as the memory needs. It aligns store data and strobes on the way out and
// extends load data on the way in. It also contains the MEM/WB register.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   valid_i .. pc_next_i  EX/MEM register contents
//   stall_o               hold EX/MEM and everything upstream this cycle
//   dmem_*                data-memory request/response port
//   valid_o .. pc_next_o  MEM/WB register contents towards WB
//   misalign_o, bus_err_o exception pulses aligned with valid_o
// Parameter TIMEOUT_CYCLES: WAIT cycles before an access is abandoned
// (0 = never time out).
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  input  data_t        alu_result_i,
  input  enable_t      mem_read_c_i,
  input  enable_t      mem_write_c_i,
  input  data_t        mem_write_data_i,
  input  mem_funct3_t  mem_funct3_i,
  input  reg_addr_t    rd_i,
  input  enable_t      reg_write_c_i,
  input  wb_data_sel_t wb_data_sel_c_i,
  input  data_t        pc_next_i,
  output logic         stall_o,
  output logic         dmem_req_o,
  output logic         dmem_we_o,
  output data_t        dmem_addr_o,
  output logic [3:0]   dmem_wstrb_o,
  output data_t        dmem_wdata_o,
  input  logic         dmem_ack_i,
  input  data_t        dmem_rdata_i,
  output logic         valid_o,
  output data_t        alu_result_o,
  output data_t        mem_rdata_o,
  output reg_addr_t    rd_o,
  output enable_t      reg_write_c_o,
  output wb_data_sel_t wb_data_sel_c_o,
  output data_t        pc_next_o,
  output logic         misalign_o,
  output logic         bus_err_o
);

  localparam int unsigned CNT_W =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // The counter starts at 0 in the first WAIT cycle, so the access expires
  // in the cycle where the counter equals TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lsu_req_t         req_q, req_d;
  memwb_t           wb_q, wb_d;

  logic  is_mem;
  logic  misaligned;
  logic  expire;
  logic  stall;
  data_t load_data;

  assign is_mem     = valid_i & (mem_read_c_i | mem_write_c_i);
  assign misaligned = access_misaligned(mem_funct3_i, mem_write_c_i,
                                        alu_result_i[1:0]);
  assign expire     = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  lsu_load_align u_load_align (
    .rdata_i   (dmem_rdata_i),
    .addr_lo_i (req_q.addr[1:0]),
    .funct3_i  (req_q.funct3),
    .data_o    (load_data)
  );

  // Next-state logic. The MEM/WB register loads every cycle. While an
  // access is stalled it loads a bubble, so WB never sees the held EX/MEM
  // instruction twice.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    stall   = 1'b0;

    wb_d.valid      = 1'b0;
    wb_d.alu_result = alu_result_i;
    wb_d.mem_rdata  = '0;
    wb_d.rd         = rd_i;
    wb_d.reg_write  = 1'b0;
    wb_d.wb_sel     = wb_data_sel_c_i;
    wb_d.pc_next    = pc_next_i;
    wb_d.misalign   = 1'b0;
    wb_d.bus_err    = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        cnt_d = '0;
        if (is_mem && !misaligned) begin
          stall           = 1'b1;
          req_d.addr      = alu_result_i;
          req_d.we        = mem_write_c_i;
          req_d.wstrb     = mem_write_c_i
                            ? store_strobe(mem_funct3_i, alu_result_i[1:0])
                            : 4'b0000;
          req_d.wdata     = mem_write_c_i
                            ? store_data(mem_funct3_i, mem_write_data_i)
                            : '0;
          req_d.funct3    = mem_funct3_i;
          req_d.rd        = rd_i;
          req_d.reg_write = reg_write_c_i;
          req_d.wb_sel    = wb_data_sel_c_i;
          req_d.pc_next   = pc_next_i;
          state_d         = LSU_WAIT;
        end else if (is_mem) begin
          // A misaligned access issues no request and retires at once
          // with its register write suppressed.
          wb_d.valid    = 1'b1;
          wb_d.misalign = 1'b1;
        end else begin
          wb_d.valid     = valid_i;
          wb_d.reg_write = valid_i & reg_write_c_i;
        end
      end

      LSU_WAIT: begin
        stall = 1'b1;
        if (dmem_ack_i || expire) begin
          // Ack takes priority over an expiry in the same cycle. Either way
          // the stall releases now, so the pipeline advances at this edge.
          stall           = 1'b0;
          state_d         = LSU_IDLE;
          cnt_d           = '0;
          wb_d.valid      = 1'b1;
          wb_d.alu_result = req_q.addr;
          wb_d.rd         = req_q.rd;
          wb_d.wb_sel     = req_q.wb_sel;
          wb_d.pc_next    = req_q.pc_next;
          if (dmem_ack_i) begin
            wb_d.reg_write = req_q.reg_write;
            wb_d.mem_rdata = req_q.we ? '0 : load_data;
          end else begin
            wb_d.bus_err = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = LSU_IDLE;
    endcase
  end

  // State, request record and MEM/WB register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      wb_q    <= wb_d;
    end
  end

  // Gated by rst_n so that every output is 0 while reset is asserted, even
  // if a memory op is sitting in EX/MEM.
  assign stall_o = stall & rst_n;

  assign dmem_req_o   = (state_q == LSU_WAIT);
  assign dmem_we_o    = req_q.we;
  assign dmem_addr_o  = {req_q.addr[31:2], 2'b00};
  assign dmem_wstrb_o = req_q.wstrb;
  assign dmem_wdata_o = req_q.wdata;

  assign valid_o         = wb_q.valid;
  assign alu_result_o    = wb_q.alu_result;
  assign mem_rdata_o     = wb_q.mem_rdata;
  assign rd_o            = wb_q.rd;
  assign reg_write_c_o   = wb_q.reg_write;
  assign wb_data_sel_c_o = wb_q.wb_sel;
  assign pc_next_o       = wb_q.pc_next;
  assign misalign_o      = wb_q.misalign;
  assign bus_err_o       = wb_q.bus_err;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed testbench for mem_stage_lsu, built with TIMEOUT_CYCLES=4.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         valid_i;
  data_t        alu_result_i;
  logic         mem_read_c_i;
  logic         mem_write_c_i;
  data_t        mem_write_data_i;
  mem_funct3_t  mem_funct3_i;
  reg_addr_t    rd_i;
  logic         reg_write_c_i;
  wb_data_sel_t wb_data_sel_c_i;
  data_t        pc_next_i;
  logic         stall_o;
  logic         dmem_req_o;
  logic         dmem_we_o;
  data_t        dmem_addr_o;
  logic [3:0]   dmem_wstrb_o;
  data_t        dmem_wdata_o;
  logic         dmem_ack_i;
  data_t        dmem_rdata_i;
  logic         valid_o;
  data_t        alu_result_o;
  data_t        mem_rdata_o;
  reg_addr_t    rd_o;
  logic         reg_write_c_o;
  wb_data_sel_t wb_data_sel_c_o;
  data_t        pc_next_o;
  logic         misalign_o;
  logic         bus_err_o;

  int checks;
  int errors;
  int stallCount;
  int reqCount;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_i          (valid_i),
    .alu_result_i     (alu_result_i),
    .mem_read_c_i     (mem_read_c_i),
    .mem_write_c_i    (mem_write_c_i),
    .mem_write_data_i (mem_write_data_i),
    .mem_funct3_i     (mem_funct3_i),
    .rd_i             (rd_i),
    .reg_write_c_i    (reg_write_c_i),
    .wb_data_sel_c_i  (wb_data_sel_c_i),
    .pc_next_i        (pc_next_i),
    .stall_o          (stall_o),
    .dmem_req_o       (dmem_req_o),
    .dmem_we_o        (dmem_we_o),
    .dmem_addr_o      (dmem_addr_o),
    .dmem_wstrb_o     (dmem_wstrb_o),
    .dmem_wdata_o     (dmem_wdata_o),
    .dmem_ack_i       (dmem_ack_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .valid_o          (valid_o),
    .alu_result_o     (alu_result_o),
    .mem_rdata_o      (mem_rdata_o),
    .rd_o             (rd_o),
    .reg_write_c_o    (reg_write_c_o),
    .wb_data_sel_c_o  (wb_data_sel_c_o),
    .pc_next_o        (pc_next_o),
    .misalign_o       (misalign_o),
    .bus_err_o        (bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts the cycles with stall or request high, sampled mid-cycle.
  always @(negedge clk) begin
    if (stall_o) stallCount++;
    if (dmem_req_o) reqCount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input data_t alu, input reg_addr_t rd,
                               input logic regw, input wb_data_sel_t sel,
                               input logic rdEn, input logic wrEn,
                               input data_t wdata, input mem_funct3_t f);
    valid_i          = v;
    alu_result_i     = alu;
    rd_i             = rd;
    reg_write_c_i    = regw;
    wb_data_sel_c_i  = sel;
    mem_read_c_i     = rdEn;
    mem_write_c_i    = wrEn;
    mem_write_data_i = wdata;
    mem_funct3_i     = f;
    pc_next_i        = alu + 32'h4;
  endtask

  task automatic bubble();
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, WB_ALU, 1'b0, 1'b0, 32'h0, LB);
  endtask

  // Load that is acknowledged in WAIT cycle nWait+1.
  task automatic runLoad(input string tag, input mem_funct3_t f, input data_t addr,
                         input data_t rdata, input int nWait, input data_t expData);
    stallCount = 0;
    applyStimulus(1'b1, addr, 5'd7, 1'b1, WB_MEM, 1'b1, 1'b0, 32'h0, f);
    tick();
    checkOutput({tag, "_addr"}, dmem_addr_o, {addr[31:2], 2'b00});
    checkOutput({tag, "_req"}, 32'(dmem_req_o), 32'd1);
    repeat (nWait) tick();
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = rdata;
    #1;
    checkOutput({tag, "_ackStall"}, 32'(stall_o), 32'd0);
    tick();
    dmem_ack_i = 1'b0;
    bubble();
    checkOutput({tag, "_rdata"}, mem_rdata_o, expData);
    checkOutput({tag, "_valid"}, 32'(valid_o), 32'd1);
    checkOutput({tag, "_rd"}, 32'(rd_o), 32'd7);
    checkOutput({tag, "_regw"}, 32'(reg_write_c_o), 32'd1);
    checkOutput({tag, "_sel"}, 32'(wb_data_sel_c_o), 32'(WB_MEM));
    checkOutput({tag, "_stalls"}, 32'(stallCount), 32'(nWait + 1));
    tick();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    stallCount   = 0;
    reqCount     = 0;
    rst_n        = 1'b0;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
    bubble();
    #12;
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_req", 32'(dmem_req_o), 32'd0);
    checkOutput("rst_alu", alu_result_o, 32'h0);
    checkOutput("rst_pc", pc_next_o, 32'h0);
    #11;
    rst_n = 1'b1;

    // Non-memory op passes straight through.
    stallCount = 0;
    applyStimulus(1'b1, 32'h10, 5'd5, 1'b1, WB_ALU, 1'b0, 1'b0, 32'h0, LB);
    tick();
    bubble();
    checkOutput("add_valid", 32'(valid_o), 32'd1);
    checkOutput("add_rd", 32'(rd_o), 32'd5);
    checkOutput("add_alu", alu_result_o, 32'h10);
    checkOutput("add_regw", 32'(reg_write_c_o), 32'd1);
    checkOutput("add_pc", pc_next_o, 32'h14);
    checkOutput("add_stalls", 32'(stallCount), 32'd0);
    tick();
    checkOutput("bubble_valid", 32'(valid_o), 32'd0);
    checkOutput("bubble_regw", 32'(reg_write_c_o), 32'd0);

    // Loads: ack in the 4th WAIT cycle (tie with timeout expiry, ack wins).
    runLoad("lb", LB, 32'h103, 32'h80FF_FFFF, 3, 32'hFFFF_FF80);
    runLoad("lbu", LBU, 32'h103, 32'h80FF_FFFF, 3, 32'h0000_0080);
    runLoad("lh", LH, 32'h102, 32'h8001_0000, 0, 32'hFFFF_8001);
    runLoad("lhu", LHU, 32'h102, 32'h8001_0000, 1, 32'h0000_8001);
    runLoad("lw", LW, 32'h104, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);

    // SH with immediate ack.
    applyStimulus(1'b1, 32'h202, 5'd0, 1'b0, WB_ALU, 1'b0, 1'b1, 32'h1234_ABCD, LH);
    #1;
    checkOutput("sh_stall", 32'(stall_o), 32'd1);
    tick();
    checkOutput("sh_we", 32'(dmem_we_o), 32'd1);
    checkOutput("sh_wstrb", 32'(dmem_wstrb_o), 32'hC);
    checkOutput("sh_wdata", dmem_wdata_o, 32'hABCD_ABCD);
    checkOutput("sh_addr", dmem_addr_o, 32'h200);
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'hFFFF_FFFF;
    tick();
    dmem_ack_i = 1'b0;
    bubble();
    checkOutput("sh_valid", 32'(valid_o), 32'd1);
    checkOutput("sh_rdata", mem_rdata_o, 32'h0);
    checkOutput("sh_req", 32'(dmem_req_o), 32'd0);
    tick();

    // SB at byte lane 1.
    applyStimulus(1'b1, 32'h101, 5'd0, 1'b0, WB_ALU, 1'b0, 1'b1, 32'h5566_7788, LB);
    tick();
    checkOutput("sb_wstrb", 32'(dmem_wstrb_o), 32'h2);
    checkOutput("sb_wdata", dmem_wdata_o, 32'h8888_8888);
    dmem_ack_i = 1'b1;
    tick();
    dmem_ack_i = 1'b0;
    bubble();
    tick();

    // Misaligned LW: no request, exception pulse.
    stallCount = 0;
    reqCount   = 0;
    applyStimulus(1'b1, 32'h301, 5'd9, 1'b1, WB_MEM, 1'b1, 1'b0, 32'h0, LW);
    #1;
    checkOutput("mis_stall", 32'(stall_o), 32'd0);
    tick();
    bubble();
    checkOutput("mis_flag", 32'(misalign_o), 32'd1);
    checkOutput("mis_valid", 32'(valid_o), 32'd1);
    checkOutput("mis_regw", 32'(reg_write_c_o), 32'd0);
    checkOutput("mis_reqs", 32'(reqCount), 32'd0);
    tick();
    checkOutput("mis_pulse", 32'(misalign_o), 32'd0);

    // Timeout: never ack.
    reqCount = 0;
    applyStimulus(1'b1, 32'h400, 5'd3, 1'b1, WB_MEM, 1'b1, 1'b0, 32'h0, LW);
    repeat (4) tick();
    checkOutput("to_lastReq", 32'(dmem_req_o), 32'd1);
    checkOutput("to_lastStall", 32'(stall_o), 32'd0);
    tick();
    bubble();
    checkOutput("to_req", 32'(dmem_req_o), 32'd0);
    checkOutput("to_berr", 32'(bus_err_o), 32'd1);
    checkOutput("to_valid", 32'(valid_o), 32'd1);
    checkOutput("to_regw", 32'(reg_write_c_o), 32'd0);
    checkOutput("to_reqCycles", 32'(reqCount), 32'd4);
    applyStimulus(1'b1, 32'h44, 5'd6, 1'b1, WB_ALU, 1'b0, 1'b0, 32'h0, LB);
    #1;
    checkOutput("resume_stall", 32'(stall_o), 32'd0);
    tick();
    bubble();
    checkOutput("resume_berr", 32'(bus_err_o), 32'd0);
    checkOutput("resume_alu", alu_result_o, 32'h44);
    tick();

    // Async reset in the middle of WAIT.
    applyStimulus(1'b1, 32'h500, 5'd2, 1'b1, WB_MEM, 1'b1, 1'b0, 32'h0, LW);
    repeat (2) tick();
    checkOutput("rw_req", 32'(dmem_req_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rw_req0", 32'(dmem_req_o), 32'd0);
    checkOutput("rw_stall0", 32'(stall_o), 32'd0);
    checkOutput("rw_addr0", dmem_addr_o, 32'h0);
    checkOutput("rw_valid0", 32'(valid_o), 32'd0);
    bubble();
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
